// File: rtl/atan2_cordic.sv
// Iterative vectoring CORDIC atan2 in 16.16 fixed point: angle in degrees plus optional magnitude.
// Define ATAN2_MAG_EN to build the gain-compensated magnitude output; otherwise mag is tied to 0.
module atan2_cordic #(
  parameter int unsigned ITER = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        busy,
  output logic        valid,
  output logic [31:0] angle,
  output logic [31:0] mag
);

  typedef enum logic [2:0] {StIdle, StPre, StRot, StPost, StDone} state_e;

  localparam logic signed [31:0] Deg180  = 32'sh00B4_0000;
  localparam logic signed [31:0] DegM180 = -32'sh00B4_0000;
  localparam logic [4:0]         LastCnt = 5'(ITER - 1);

  state_e             r_state;
  logic signed [33:0] r_x, r_y;
  logic signed [31:0] r_z;
  logic [4:0]         r_cnt;
  logic               r_yzero, r_xneg;
  logic               r_busy, r_valid;
  logic [31:0]        r_angle, r_mag;

  logic signed [33:0] w_xs, w_ys;
  logic signed [31:0] w_t;
  logic [31:0]        w_angle, w_mag;

  // round(atan(2^-i) degrees * 65536)
  function automatic logic signed [31:0] atan_tab(input logic [4:0] i);
    case (i)
      5'd0:    atan_tab = 32'sh002D_0000;
      5'd1:    atan_tab = 32'sh001A_90A7;
      5'd2:    atan_tab = 32'sh000E_0947;
      5'd3:    atan_tab = 32'sh0007_2001;
      5'd4:    atan_tab = 32'sh0003_938B;
      5'd5:    atan_tab = 32'sh0001_CA38;
      5'd6:    atan_tab = 32'sh0000_E52A;
      5'd7:    atan_tab = 32'sh0000_7297;
      5'd8:    atan_tab = 32'sh0000_394C;
      5'd9:    atan_tab = 32'sh0000_1CA6;
      5'd10:   atan_tab = 32'sh0000_0E53;
      5'd11:   atan_tab = 32'sh0000_0729;
      5'd12:   atan_tab = 32'sh0000_0395;
      5'd13:   atan_tab = 32'sh0000_01CA;
      5'd14:   atan_tab = 32'sh0000_00E5;
      5'd15:   atan_tab = 32'sh0000_0073;
      5'd16:   atan_tab = 32'sh0000_0039;
      5'd17:   atan_tab = 32'sh0000_001D;
      5'd18:   atan_tab = 32'sh0000_000E;
      5'd19:   atan_tab = 32'sh0000_0007;
      5'd20:   atan_tab = 32'sh0000_0004;
      5'd21:   atan_tab = 32'sh0000_0002;
      5'd22:   atan_tab = 32'sh0000_0001;
      default: atan_tab = 32'sh0000_0000;
    endcase
  endfunction

  assign w_xs = r_x >>> r_cnt;
  assign w_ys = r_y >>> r_cnt;
  assign w_t  = atan_tab(r_cnt);

  // Axis inputs (y==0) bypass the rotation residue so 0, 180 and the origin come out exact.
  always_comb begin
    w_angle = r_z;
    if (r_yzero) begin
      w_angle = r_xneg ? Deg180 : 32'h0;
    end else if (r_z == DegM180) begin
      w_angle = Deg180;
    end
  end

`ifdef ATAN2_MAG_EN
  logic signed [50:0] w_prod, w_shift;
  assign w_prod  = 51'(r_x) * 51'sd39797;
  assign w_shift = w_prod >>> 16;
  always_comb begin
    if (w_shift[50]) begin
      w_mag = 32'h0;
    end else if (|w_shift[49:32]) begin
      w_mag = 32'hFFFF_FFFF;
    end else begin
      w_mag = w_shift[31:0];
    end
  end
`else
  assign w_mag = 32'h0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_cnt   <= '0;
      r_yzero <= 1'b0;
      r_xneg  <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_angle <= '0;
      r_mag   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            r_x     <= {{2{x[31]}}, x};
            r_y     <= {{2{y[31]}}, y};
            r_yzero <= (y == 32'h0);
            r_xneg  <= x[31];
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= StPre;
          end
        end
        StPre: begin
          if (r_x[33]) begin
            r_x <= -r_x;
            r_y <= -r_y;
            r_z <= r_y[33] ? DegM180 : Deg180;
          end else begin
            r_z <= '0;
          end
          r_state <= StRot;
        end
        StRot: begin
          if (!r_y[33]) begin
            r_x <= r_x + w_ys;
            r_y <= r_y - w_xs;
            r_z <= r_z + w_t;
          end else begin
            r_x <= r_x - w_ys;
            r_y <= r_y + w_xs;
            r_z <= r_z - w_t;
          end
          if (r_cnt == LastCnt) begin
            r_state <= StPost;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        StPost: begin
          r_angle <= w_angle;
          r_mag   <= w_mag;
          r_busy  <= 1'b0;
          r_valid <= 1'b1;
          r_state <= StDone;
        end
        StDone: begin
          r_valid <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy  = r_busy;
  assign valid = r_valid;
  assign angle = r_angle;
  assign mag   = r_mag;

endmodule
